// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Widest pipeline the helpers below can describe.
    localparam int MAX_NSTAGE = 32;

    typedef logic [MAX_NSTAGE-1:0] stage_vec_t;

    localparam stage_vec_t STALL_NONE = '0;
    localparam stage_vec_t STALL_ALL  = '1;

    // Width needed to encode a flush depth of 0..n stages.
    function automatic int fsw_of(input int n);
        return $clog2(n + 1);
    endfunction

    // Index of the highest set bit, or -1 when the vector is empty.
    function automatic int hi_idx(input stage_vec_t v);
        int h;
        h = -1;
        for (int i = 0; i < MAX_NSTAGE; i++) begin
            if (v[i]) h = i;
        end
        return h;
    endfunction

endpackage

// File: rtl/pipe_wdog.sv
// Stall watchdog: saturating run-length counter with a sticky timeout flag.
// Latency: flag sets on the edge that completes LIMIT consecutive active cycles.
// Backpressure: none; clr has priority over a coincident set.
module pipe_wdog #(
    parameter int W     = 16,
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clr,
    output logic timeout
);

    logic [W-1:0] cnt;

    // Count consecutive active cycles, holding at all ones; any idle cycle restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

    // Sticky flag: set when the run reaches the limit, cleared only by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (clr) begin
            timeout <= 1'b0;
        end else if (active && (cnt == W'(LIMIT - 1))) begin
            timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage stall/bubble/flush generator for an NSTAGE in-order pipeline.
// Latency: stall/bubble same cycle; flush issues >=1 cycle after flush_req.
// Backpressure: stallreq_glb stalls all stages and holds any pending flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE     = 6,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 1023,
    parameter int PERF_W     = 32,
    localparam int FSW       = fsw_of(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              stallreq_glb,
    input  logic              flush_req,
    input  logic [FSW-1:0]    flush_stage,
    input  logic              wdog_clr,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              flush_pending,
    output logic              wdog_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    // NSTAGE must not exceed MAX_NSTAGE from the package.

    logic              pending;
    logic [FSW-1:0]    pend_s;
    logic [FSW-1:0]    clamp_s;
    logic              new_flush;
    logic              issue;
    stage_vec_t        req_ext;
    int                hi;
    logic [NSTAGE-1:0] raw;
    logic [NSTAGE-1:0] bub;
    logic [NSTAGE-1:0] fl;

    assign clamp_s   = (int'(flush_stage) > NSTAGE) ? FSW'(NSTAGE) : flush_stage;
    assign new_flush = flush_req && (flush_stage != '0);
    assign issue     = pending && !stallreq_glb;

    // Stall everything up to the oldest requester, bubble the stage behind it, flush the pending depth.
    always_comb begin
        req_ext               = STALL_NONE;
        req_ext[NSTAGE-1:0]   = stallreq;
        hi                    = hi_idx(req_ext);
        raw                   = '0;
        bub                   = '0;
        fl                    = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            raw[k] = stallreq_glb || (hi >= k);
            fl[k]  = issue && (k < int'(pend_s));
        end
        if (stallreq_glb) begin
            raw = STALL_ALL[NSTAGE-1:0];
        end else if ((hi >= 0) && (hi < NSTAGE - 1)) begin
            bub[hi+1] = 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted; a flushed stage is never held.
    always_comb begin
        stall  = '0;
        bubble = '0;
        flush  = '0;
        if (rst_n) begin
            stall  = raw & ~fl;
            bubble = bub;
            flush  = fl;
        end
    end

    // Capture flush requests; merge to the deeper one while held, or replace after an issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            pend_s  <= '0;
        end else if (issue) begin
            pending <= new_flush;
            if (new_flush) pend_s <= clamp_s;
        end else if (new_flush) begin
            pending <= 1'b1;
            if (!pending || (clamp_s > pend_s)) pend_s <= clamp_s;
        end
    end

    assign flush_pending = pending;

    // Count cycles in which the fetch stage is held; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall[0]) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    pipe_wdog #(
        .W     (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (|stall),
        .clr     (wdog_clr),
        .timeout (wdog_timeout)
    );

endmodule
